// File: rtl/i2c_pkg.sv
// Shared constants and types for the I2C slave bus front end.
// Holds the default slave address, byte/bit-counter sizing, the
// glitch-filter hold threshold and a counter increment helper.
package i2c_pkg;

   localparam logic [6:0] I2C_DEFAULT_ADDR = 7'h49;
   localparam int         BITS_PER_BYTE    = 8;
   localparam int         BITCNT_W         = 4;

   typedef logic [BITCNT_W-1:0] bitcnt_t;

   // Counter value meaning "a whole byte has been clocked".
   localparam bitcnt_t BITCNT_FULL = bitcnt_t'(BITS_PER_BYTE);

   // Filter stability count reached on the clock before the filtered
   // value is allowed to follow the synchronized input.
   localparam logic [1:0] FILTER_HOLD = 2'd2;

   function automatic bitcnt_t bitcnt_inc(input bitcnt_t c);
      return c + bitcnt_t'(1);
   endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Single-line conditioner: SYNC_STAGES-deep synchronizer, optional
// glitch filter (macro I2C_GLITCH_FILTER_EN), then one delay flop.
// Ports: clock, reset (async, active-high), line_i (raw pin),
// line_s_o (conditioned level), line_d_o (line_s_o delayed one clock).
import i2c_pkg::*;

module i2c_line_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clock,
   input  logic reset,
   input  logic line_i,
   output logic line_s_o,
   output logic line_d_o
);

   // Idle I2C lines are high, so every flop resets to 1 to avoid
   // fake edges or START/STOP conditions right after reset.
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync_out;
   logic                   line_dly_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync_q <= '1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], line_i};
      end
   end

   assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef I2C_GLITCH_FILTER_EN
   // The filtered level follows the synchronizer only after they have
   // disagreed on three consecutive clocks; any agreement restarts it.
   logic       filt_q, filt_d;
   logic [1:0] stab_q, stab_d;

   always_comb begin
      filt_d = filt_q;
      stab_d = 2'd0;
      if (sync_out != filt_q) begin
         if (stab_q == FILTER_HOLD) begin
            filt_d = sync_out;
         end else begin
            stab_d = stab_q + 2'd1;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         filt_q <= 1'b1;
         stab_q <= 2'd0;
      end else begin
         filt_q <= filt_d;
         stab_q <= stab_d;
      end
   end

   assign line_s_o = filt_q;
`else
   assign line_s_o = sync_out;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         line_dly_q <= 1'b1;
      end else begin
         line_dly_q <= line_s_o;
      end
   end

   assign line_d_o = line_dly_q;

endmodule

// File: rtl/i2c_bus_frontend.sv
// Bus-facing front end of the I2C slave: conditions SCL/SDA, emits SCL
// edge strobes, sticky START/STOP flags, bit counter, shift register,
// address match and ACK sample. Optional filter: I2C_GLITCH_FILTER_EN.
// Ports: clock/reset; scl_in/sda_in raw pins; clear_start/clear_stop/
// clear_counter/in_enable from the FSM; start/stop flags, SCL strobes,
// counted_8, addr_valid, ACK and data_in back to the FSM.
import i2c_pkg::*;

module i2c_bus_frontend #(
   parameter logic [6:0] SLAVE_ADDR  = I2C_DEFAULT_ADDR,
   parameter int         SYNC_STAGES = 2
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       scl_in,
   input  logic       sda_in,
   input  logic       clear_start,
   input  logic       clear_stop,
   input  logic       clear_counter,
   input  logic       in_enable,
   output logic       start,
   output logic       stop,
   output logic       SCL_negedge,
   output logic       SCL_posedge,
   output logic       counted_8,
   output logic       addr_valid,
   output logic       ACK,
   output logic [7:0] data_in
);

   logic scl_s, scl_d, sda_s, sda_d;

   i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
      .clock    (clock),
      .reset    (reset),
      .line_i   (scl_in),
      .line_s_o (scl_s),
      .line_d_o (scl_d)
   );

   i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
      .clock    (clock),
      .reset    (reset),
      .line_i   (sda_in),
      .line_s_o (sda_s),
      .line_d_o (sda_d)
   );

   logic    scl_pos, scl_neg, start_cond, stop_cond, below_full;
   logic    start_q, start_d, stop_q, stop_d, ack_q, ack_d;
   bitcnt_t cnt_q, cnt_d;
   logic [7:0] data_q, data_d;

   assign scl_neg = scl_d & ~scl_s;
   assign scl_pos = ~scl_d & scl_s;

   // SCL must be high on both samples so SDA moving around an SCL edge
   // is treated as data rather than START/STOP.
   assign start_cond = scl_s & scl_d &  sda_d & ~sda_s;
   assign stop_cond  = scl_s & scl_d & ~sda_d &  sda_s;

   assign below_full = (cnt_q < BITCNT_FULL);

   always_comb begin
      start_d = start_q;
      stop_d  = stop_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      ack_d   = ack_q;

      // A new detect wins over a simultaneous clear so no event is lost.
      if (start_cond) begin
         start_d = 1'b1;
      end else if (clear_start) begin
         start_d = 1'b0;
      end

      if (stop_cond) begin
         stop_d = 1'b1;
      end else if (clear_stop) begin
         stop_d = 1'b0;
      end

      // Counting ignores in_enable so the FSM also sees counted_8 while
      // it is transmitting; the count saturates at a full byte.
      if (clear_counter || start_cond || stop_cond) begin
         cnt_d = '0;
      end else if (scl_pos && below_full) begin
         cnt_d = bitcnt_inc(cnt_q);
      end

      // The byte register is never cleared so the FSM can still read it
      // after START/STOP or a counter clear.
      if (scl_pos && in_enable && below_full) begin
         data_d = {data_q[6:0], sda_s};
      end

      if (scl_pos) begin
         ack_d = ~sda_s;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         start_q <= 1'b0;
         stop_q  <= 1'b0;
         cnt_q   <= '0;
         data_q  <= 8'h00;
         ack_q   <= 1'b0;
      end else begin
         start_q <= start_d;
         stop_q  <= stop_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         ack_q   <= ack_d;
      end
   end

   assign start       = start_q;
   assign stop        = stop_q;
   assign SCL_negedge = scl_neg;
   assign SCL_posedge = scl_pos;
   assign counted_8   = (cnt_q == BITCNT_FULL);
   assign addr_valid  = counted_8 && (data_q[7:1] == SLAVE_ADDR);
   assign ACK         = ack_q;
   assign data_in     = data_q;

endmodule

// File: tb/tb_i2c_bus_frontend.sv
// Directed bench for i2c_bus_frontend: START + address, wrong address,
// ACK sampling, repeated START, STOP, in_enable gating, SCL glitch and
// asynchronous reset, each with hand-computed expected values.
module tb_i2c_bus_frontend;

   logic       clock = 1'b0;
   logic       reset;
   logic       scl_in, sda_in;
   logic       clear_start, clear_stop, clear_counter, in_enable;
   logic       start, stop, SCL_negedge, SCL_posedge;
   logic       counted_8, addr_valid, ACK;
   logic [7:0] data_in;

   localparam int H = 8;   // clocks per SCL phase
`ifdef I2C_GLITCH_FILTER_EN
   localparam int SLAT = 5;
`else
   localparam int SLAT = 2;
`endif

   i2c_bus_frontend #(.SLAVE_ADDR(7'h49), .SYNC_STAGES(2)) dut (
      .clock         (clock),
      .reset         (reset),
      .scl_in        (scl_in),
      .sda_in        (sda_in),
      .clear_start   (clear_start),
      .clear_stop    (clear_stop),
      .clear_counter (clear_counter),
      .in_enable     (in_enable),
      .start         (start),
      .stop          (stop),
      .SCL_negedge   (SCL_negedge),
      .SCL_posedge   (SCL_posedge),
      .counted_8     (counted_8),
      .addr_valid    (addr_valid),
      .ACK           (ACK),
      .data_in       (data_in)
   );

   always #5 clock = ~clock;

   int n_asserts = 0;
   int n_fail    = 0;
   int pos_cnt   = 0;
   int neg_cnt   = 0;
   int p0, n0;

   always @(negedge clock) begin
      if (SCL_posedge) pos_cnt <= pos_cnt + 1;
      if (SCL_negedge) neg_cnt <= neg_cnt + 1;
   end

   task automatic chk1(input string tag, input logic obs, input logic expv);
      n_asserts++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, expv);
      end
   endtask

   task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      n_asserts++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %02h expected %02h", tag, obs, expv);
      end
   endtask

   task automatic chkn(input string tag, input int obs, input int expv);
      n_asserts++;
      assert (obs == expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   // Entered and left with SCL low.
   task automatic send_bit(input logic b);
      sda_in = b;
      cyc(H);
      scl_in = 1'b1;
      cyc(H);
      scl_in = 1'b0;
      cyc(H);
   endtask

   task automatic send_byte_chk(input logic [7:0] b, input string tag);
      int pb, nb;
      pb = pos_cnt;
      nb = neg_cnt;
      for (int i = 7; i >= 0; i--) begin
         send_bit(b[i]);
         if (i == 1) chk1({tag, "_cnt7"}, counted_8, 1'b0);
      end
      chk1({tag, "_cnt8"}, counted_8, 1'b1);
      chkn({tag, "_posedges"}, pos_cnt - pb, 8);
      chkn({tag, "_negedges"}, neg_cnt - nb, 8);
   endtask

   task automatic pulse_clear_counter();
      clear_counter = 1'b1;
      cyc(1);
      clear_counter = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      scl_in = 1'b1;
      sda_in = 1'b1;
      clear_start = 1'b0;
      clear_stop = 1'b0;
      clear_counter = 1'b0;
      in_enable = 1'b0;
      cyc(3);
      reset = 1'b0;

      // Reset state and a quiet idle bus.
      chk1("rst_start", start, 1'b0);
      chk1("rst_stop", stop, 1'b0);
      chk1("rst_ack", ACK, 1'b0);
      chk1("rst_counted8", counted_8, 1'b0);
      chk1("rst_addr_valid", addr_valid, 1'b0);
      chk8("rst_data_in", data_in, 8'h00);
      chk1("rst_negedge", SCL_negedge, 1'b0);
      chk1("rst_posedge", SCL_posedge, 1'b0);
      p0 = pos_cnt;
      n0 = neg_cnt;
      cyc(20);
      chkn("idle_strobes", (pos_cnt - p0) + (neg_cnt - n0), 0);

      // START: SDA falls with SCL high.
      sda_in = 1'b0;
      cyc(SLAT);
      chk1("start_pre", start, 1'b0);
      cyc(1);
      chk1("start_set", start, 1'b1);
      cyc(H);
      scl_in = 1'b0;
      cyc(H);

      // Matching address 0x49 + write.
      in_enable = 1'b1;
      send_byte_chk(8'h92, "addr_ok");
      chk8("addr_ok_data", data_in, 8'h92);
      chk1("addr_ok_valid", addr_valid, 1'b1);
      chk1("addr_ok_rw", data_in[0], 1'b0);

      // 9th clock, SDA low: ACK seen, counter saturated, no shift.
      send_bit(1'b0);
      chk1("ack_low", ACK, 1'b1);
      chk1("sat_counted8", counted_8, 1'b1);
      chk8("sat_data", data_in, 8'h92);

      clear_start = 1'b1;
      cyc(1);
      clear_start = 1'b0;
      chk1("start_cleared", start, 1'b0);
      pulse_clear_counter();
      chk1("cnt_cleared", counted_8, 1'b0);

      // Wrong address 0x4A.
      send_byte_chk(8'h94, "addr_bad");
      chk8("addr_bad_data", data_in, 8'h94);
      chk1("addr_bad_valid", addr_valid, 1'b0);
      chk1("data_no_start", start, 1'b0);
      chk1("data_no_stop", stop, 1'b0);
      send_bit(1'b1);
      chk1("ack_high", ACK, 1'b0);

      // Repeated START after 5 bits, with clear_start held over the detect.
      pulse_clear_counter();
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      sda_in = 1'b1;
      cyc(H);
      scl_in = 1'b1;
      cyc(H);
      clear_start = 1'b1;
      sda_in = 1'b0;
      cyc(SLAT + 1);
      chk1("rs_set_wins", start, 1'b1);
      chk1("rs_cnt_zero", counted_8, 1'b0);
      clear_start = 1'b0;
      cyc(H);
      scl_in = 1'b0;
      cyc(H);
      send_byte_chk(8'h92, "rs_byte");
      chk8("rs_data", data_in, 8'h92);
      chk1("rs_addr_valid", addr_valid, 1'b1);

      // STOP: SDA rises with SCL high.
      sda_in = 1'b0;
      cyc(H);
      scl_in = 1'b1;
      cyc(H);
      sda_in = 1'b1;
      cyc(SLAT);
      chk1("stop_pre", stop, 1'b0);
      cyc(1);
      chk1("stop_set", stop, 1'b1);
      chk1("stop_cnt_zero", counted_8, 1'b0);
      chk8("stop_data_kept", data_in, 8'h92);
      clear_stop = 1'b1;
      cyc(1);
      clear_stop = 1'b0;
      chk1("stop_cleared", stop, 1'b0);

      // in_enable low: counting continues, data_in holds.
      scl_in = 1'b0;
      cyc(H);
      in_enable = 1'b0;
      pulse_clear_counter();
      send_byte_chk(8'h5A, "noen");
      chk8("noen_data", data_in, 8'h92);
      send_bit(1'b0);
      chk1("noen_ack", ACK, 1'b1);
      sda_in = 1'b1;
      cyc(H);
      scl_in = 1'b1;
      cyc(H);
      chk1("sda_rise_scl_low_no_stop", stop, 1'b0);

      // Two-clock SCL low glitch on an idle bus.
      p0 = pos_cnt;
      n0 = neg_cnt;
      scl_in = 1'b0;
      cyc(2);
      scl_in = 1'b1;
      cyc(12);
`ifdef I2C_GLITCH_FILTER_EN
      chkn("glitch_negedges", neg_cnt - n0, 0);
      chkn("glitch_posedges", pos_cnt - p0, 0);
`else
      chkn("glitch_negedges", neg_cnt - n0, 1);
      chkn("glitch_posedges", pos_cnt - p0, 1);
`endif

      // Asynchronous reset mid-byte.
      scl_in = 1'b0;
      cyc(H);
      send_bit(1'b1);
      send_bit(1'b0);
      chk1("pre_reset_ack", ACK, 1'b1);
      reset = 1'b1;
      #1;
      chk8("async_rst_data", data_in, 8'h00);
      chk1("async_rst_ack", ACK, 1'b0);
      chk1("async_rst_counted8", counted_8, 1'b0);
      cyc(3);
      reset = 1'b0;
      cyc(10);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule

// File: doc/i2c_bus_frontend.md
# i2c_bus_frontend

- Bus-facing front end of the I2C slave; sits directly upstream of the slave control FSM.
- Synchronizes the raw SCL/SDA pins and produces SCL edge strobes.
- Detects START/STOP conditions as sticky flags that the FSM clears.
- Shifts received bits into a byte register, counts bits, compares the address, and samples the master's ACK.

## Interface
- `SLAVE_ADDR`, default 7'h49: 7-bit address this slave answers to.
- `SYNC_STAGES`, default 2: synchronizer depth per line, minimum 2.
- `clock` in 1: system clock; all state on its rising edge.
- `reset` in 1: asynchronous, active-high.
- `scl_in` in 1: raw SCL pin, asynchronous.
- `sda_in` in 1: raw SDA pin, asynchronous.
- `clear_start` in 1: clears the `start` flag.
- `clear_stop` in 1: clears the `stop` flag.
- `clear_counter` in 1: zeroes the bit counter.
- `in_enable` in 1: permits shifting SDA into `data_in`.
- `start` out 1: sticky START-condition flag.
- `stop` out 1: sticky STOP-condition flag.
- `SCL_negedge` out 1: one-cycle strobe on a synchronized SCL fall.
- `SCL_posedge` out 1: one-cycle strobe on a synchronized SCL rise.
- `counted_8` out 1: bit counter equals 8.
- `addr_valid` out 1: `counted_8` and `data_in[7:1] == SLAVE_ADDR`.
- `ACK` out 1: master ACK, 1 = SDA sampled low.
- `data_in` out 8: shift register, MSB first; `data_in[0]` holds R/W after the address byte.

## Operation
- **Line conditioning.** Each line passes through a `SYNC_STAGES` flop chain giving `scl_s`/`sda_s`, then one delay flop giving `scl_d`/`sda_d`. All of these flops reset to 1 (idle bus).
- **Edge strobes.**
  - `SCL_negedge = scl_d & ~scl_s`.
  - `SCL_posedge = ~scl_d & scl_s`.
  - Both are combinational from registers, so each is high for exactly one cycle.
- **START detect.**
  - Condition: `scl_s & scl_d & sda_d & ~sda_s` (SDA falls while SCL stays high).
  - Sets `start` on the next edge.
  - `clear_start` clears it. If set and clear occur in the same cycle, set wins.
- **STOP detect.**
  - Condition: `scl_s & scl_d & ~sda_d & sda_s` (SDA rises while SCL stays high).
  - Sets `stop`; `clear_stop` clears it. Set wins over clear.
- **SDA changes while SCL is low or changing** are data, never START or STOP.
- **Bit counter** (4-bit), priority high to low:
  1. `clear_counter`, START detect, or STOP detect → 0.
  2. Else `SCL_posedge` with count < 8 → count + 1.
  3. The counter saturates at 8.
- **Counting is not gated by `in_enable`.** This gives the FSM `counted_8` during transmit phases.
- **Shift register.** On `SCL_posedge` with `in_enable` and count < 8: `data_in <= {data_in[6:0], sda_s}`.
  - Not cleared by `clear_counter`, START, or STOP.
  - Holds its value until the next enabled shift.
- **ACK.** On every `SCL_posedge`, `ACK <= ~sda_s`; otherwise it holds.
- **`counted_8` and `addr_valid`** are combinational from the counter and `data_in`.

## Timing
- **Reset values:**
  - Synchronizer and delay flops: 1.
  - `start`, `stop`, `ACK`: 0.
  - Counter: 0.
  - `data_in`: 8'h00.
  - All strobes: 0.
- **Pin-to-strobe latency:** a pin change is first reflected in `scl_s`/`sda_s` after `SYNC_STAGES` clock edges. The strobe or condition is then active in the following cycle.
- **`start`/`stop`:** set one edge after the detect condition.
- **Counter, `data_in`, and `ACK`:** update on the edge where `SCL_posedge` is high. They are visible the next cycle, before the matching `SCL_negedge`, provided SCL high time ≥ 2 clocks.
- **Minimum SCL high and low time:** 2 clock cycles (3 with the filter).
- **Reset mid-byte:** all state returns to reset values immediately.
  - If the pins are low when reset releases, a spurious `SCL_negedge` may follow; the FSM ignores it in RESET/INIT.
- **Repeated START mid-byte:** `start` sets and the counter zeroes in the same edge.

## Configuration
- **`I2C_GLITCH_FILTER_EN` defined:**
  - A 2-bit stability counter per line sits after the synchronizer.
  - The filtered value changes only after the synchronized input has differed from it for 3 consecutive clocks.
  - Pulses of 2 clocks or fewer are suppressed; latency increases by 3 cycles.
- **Undefined:** no filter; synchronizer output drives the edge logic directly.

## Structure
- **Package `i2c_pkg`:**
  - `I2C_DEFAULT_ADDR = 7'h49`.
  - `BITS_PER_BYTE = 8`.
  - `BITCNT_W = 4`.
  - Typedef `bitcnt_t`.
- **Sub-module `i2c_line_sync`:** synchronizer chain plus the optional filter. Instantiated twice, once for SCL and once for SDA.

## Test plan
- **Reset:** pins held high, `reset` pulsed → all outputs 0, `data_in = 8'h00`, no strobes for 20 cycles.
- **START then address:**
  - Stimulus: SDA falls while SCL is high, then byte 0x92 clocked in with `in_enable = 1`.
  - Required: `start` = 1 after 3 cycles; `counted_8` = 1 after the 8th rising edge; `data_in = 8'h92`; `addr_valid = 1`; `data_in[0] = 0`.
- **Wrong address:** byte 0x94 clocked in → `counted_8 = 1`, `addr_valid = 0`.
- **ACK sampling:**
  - 9th clock with SDA low → `ACK = 1`.
  - Repeated with SDA high → `ACK = 0`.
- **Repeated START after 5 bits:** `start` set, counter 0, `counted_8` stays 0 until 8 new rising edges. Simultaneous `clear_start` and detect → `start = 1`.
- **STOP and filter:**
  - SDA rises while SCL is high → `stop = 1`; `clear_stop` → 0.
  - With `I2C_GLITCH_FILTER_EN`, a 2-clock SCL low glitch → no `SCL_negedge`.
